egg_timer_ctrl: RTL
===================

# egg_timer_ctrl

Top-level control FSM for the egg timer, downstream of the per-button debouncers. It turns three debounced button levels into press events with auto-repeat and uses them to set a minute count. It then runs a one-second prescaled countdown in mm:ss, supports pause/resume and cancel, and raises an alarm at 00:00. Its outputs feed the display driver and the buzzer.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per countdown second; must be ≥2.
- `MAX_MIN`, default 99: maximum settable minutes; must be ≤127.
- `REPEAT_DELAY`, default 25_000_000: cycles a set button is held before the first auto-repeat step.
- `REPEAT_PERIOD`, default 5_000_000: cycles between later auto-repeat steps; must be ≥1 and ≤`REPEAT_DELAY`.
- `ALARM_SECS`, default 30: seconds before the alarm clears itself; must be ≥1.
- `clk` input 1: single system clock.
- `rst` input 1: reset, synchronous and active-low.
- `btn_start` input 1: debounced start/pause level.
- `btn_up` input 1: debounced minute-increment level.
- `btn_down` input 1: debounced minute-decrement / cancel level.
- `minutes` output 7: remaining minutes, 0..`MAX_MIN`.
- `seconds` output 6: remaining seconds, 0..59.
- `running` output 1: high in RUN.
- `alarm` output 1: high in ALARM.
- `state` output 2: current FSM state, encoded per the package.

## Operation
- Edge detection: each button has a `prev` register that resets to 0. A press is `btn & ~prev`.
- Auto-repeat, IDLE only, applies to `btn_up` or `btn_down` held alone:
  - The press itself produces one step and clears the hold counter.
  - While the button stays high, the counter increments each cycle.
  - When the counter reaches `REPEAT_DELAY-1`, another step fires and the counter reloads to `REPEAT_DELAY-REPEAT_PERIOD`.
  - Releasing the button, or both set buttons high together, clears the counter and produces no step.
- States, encoded IDLE=0, RUN=1, PAUSE=2, ALARM=3:
  - IDLE:
    - An up step sets minutes+1, saturating at `MAX_MIN`.
    - A down step sets minutes−1, saturating at 0.
    - `seconds` is held at 0.
    - Up and down presses in the same cycle: no change.
    - A start press with a nonzero time goes to RUN and clears the prescaler. With 00:00 it is ignored.
    - A start press in the same cycle as an up/down step: start wins and the step is dropped.
  - RUN:
    - The prescaler counts 0..`TICK_DIV-1`. At its terminal count it wraps to 0 and decrements the time: if ss>0 then ss−1, else ss=59 and mm−1.
    - If the decremented time is 00:00, go to ALARM.
    - A start press goes to PAUSE with the prescaler held.
    - Up and down are ignored.
  - PAUSE:
    - Time and prescaler are frozen.
    - A start press goes to RUN and the prescaler resumes from its held value.
    - A down press clears the time to 00:00 and goes to IDLE.
    - Up is ignored.
    - Start and down in the same cycle: down (cancel) wins.
  - ALARM:
    - Time reads 00:00.
    - Any button press goes to IDLE.
    - Otherwise, after `ALARM_SECS` prescaler wraps, go to IDLE automatically.
- Simultaneous events in RUN:
  - Terminal tick and start press together: the decrement is applied and the state becomes PAUSE.
  - If that decrement reaches 00:00, ALARM wins over PAUSE.
- Reset:
  - Clears all state: IDLE, 00:00, prescaler, hold counters, alarm-seconds counter, and `prev` registers.
  - Reset mid-RUN or mid-ALARM returns to IDLE with no residual alarm.
  - A button already held when reset deasserts registers as a press on the first cycle after reset.

## Timing
- Reset values: `minutes`=0, `seconds`=0, `running`=0, `alarm`=0, `state`=0.
- All outputs are registered.
- A button that goes high at cycle N has its effect visible on the outputs at cycle N+1.
- RUN entered at cycle N: the first decrement is visible at cycle N+`TICK_DIV`, then every `TICK_DIV` cycles.
- `running` and `alarm` change in the same cycle as `state`.
- Auto-repeat: with the press seen at cycle N, steps occur at N, N+`REPEAT_DELAY`, then every `REPEAT_PERIOD` cycles.

## Structure
- Package `egg_timer_pkg` holds:
  - the `timer_state_t` enum (2 bits, encodings above);
  - the `MIN_W`=7 and `SEC_W`=6 width constants;
  - the `SEC_MAX`=59 constant.
- Sub-module `btn_edge_repeat`:
  - parameters `REPEAT_DELAY` and `REPEAT_PERIOD`;
  - ports `clk`, `rst`, `btn`, `enable`, `inhibit`; output `step`;
  - instantiated twice, for up and down;
  - `btn_start` uses plain edge detection in the top level.
- Prescaler width is `$clog2(TICK_DIV)`. Hold counter width is `$clog2(REPEAT_DELAY)`.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `REPEAT_DELAY`=8, `REPEAT_PERIOD`=2, `MAX_MIN`=99, `ALARM_SECS`=3.
- Set and run: two up presses, then start → 02:00 and RUN. After 4 cycles 01:59; after 480 total cycles 00:00, ALARM, `alarm`=1.
- Auto-repeat: up held 20 cycles from 00:00 in IDLE → steps at offsets 0, 8, 10, 12, 14, 16, 18 → 07:00. Down presses at 00:00 keep 00:00; up beyond 99 stays at 99.
- Pause and cancel:
  - Start during RUN at 00:59 → PAUSE, time frozen 10 cycles. Start → resumes, 00:58 after the remaining prescaler cycles.
  - Pause again, down press → IDLE at 00:00.
- Simultaneous events:
  - Start edge on a terminal tick at 01:00 → 00:59 and PAUSE.
  - Start edge on a terminal tick at 00:01 → ALARM.
  - Up and down edges together in IDLE → no change.
- Alarm exit: ALARM with no input → IDLE after 12 cycles. A repeat run with `btn_down` pressed in ALARM → IDLE the next cycle.
- Reset: `rst`=0 for one cycle mid-RUN at 03:17 → next cycle IDLE, 00:00, `running`=0. `btn_start` held through reset → RUN is not entered because the time is zero.

Source files
------------

// File: rtl/egg_timer_pkg.sv
// Shared types and widths for the egg timer control block.
// State encoding is visible on the top-level state port.
package egg_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } timer_state_t;

    localparam int MIN_W = 7;
    localparam int SEC_W = 6;
    localparam logic [SEC_W-1:0] SEC_MAX = 6'd59;

endpackage

// File: rtl/btn_edge_repeat.sv
// Edge detector with hold-to-repeat for one debounced set button.
// Steps only while enabled and not inhibited by the other set button.
module btn_edge_repeat #(
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    input  logic enable,
    input  logic inhibit,
    output logic step
);

    localparam int HW = (REPEAT_DELAY > 1) ? $clog2(REPEAT_DELAY) : 1;
    localparam logic [HW-1:0] LAST   = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RELOAD = HW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic          prev;
    logic [HW-1:0] hold;
    logic          press;
    logic          active;

    always_comb begin
        press  = btn & ~prev;
        active = btn & enable & ~inhibit;
        step   = active & (press | (hold == LAST));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev <= 1'b0;
            hold <= '0;
        end else begin
            prev <= btn;
            if (!active || press)
                hold <= '0;
            else if (hold == LAST)
                hold <= RELOAD;
            else
                hold <= hold + 1'b1;
        end
    end

endmodule

// File: rtl/egg_timer_ctrl.sv
// Egg timer control: minute setting, mm:ss countdown, pause/cancel
// and a self-clearing alarm.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV      = 50_000_000,
    parameter int MAX_MIN       = 99,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 5_000_000,
    parameter int ALARM_SECS    = 30
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_start,
    input  logic             btn_up,
    input  logic             btn_down,
    output logic [MIN_W-1:0] minutes,
    output logic [SEC_W-1:0] seconds,
    output logic             running,
    output logic             alarm,
    output logic [1:0]       state
);

    localparam int PW  = $clog2(TICK_DIV);
    localparam int ASW = (ALARM_SECS > 1) ? $clog2(ALARM_SECS) : 1;
    localparam logic [PW-1:0]    PS_LAST = PW'(TICK_DIV - 1);
    localparam logic [ASW-1:0]   AS_LAST = ASW'(ALARM_SECS - 1);
    localparam logic [MIN_W-1:0] MM_MAX  = MIN_W'(MAX_MIN);

    timer_state_t     st_q, st_n;
    logic [MIN_W-1:0] mm_q, mm_n, mm_dec;
    logic [SEC_W-1:0] ss_q, ss_n, ss_dec;
    logic [PW-1:0]    presc_q, presc_n;
    logic [ASW-1:0]   asec_q, asec_n;
    logic             running_q, alarm_q;
    logic             prev_start, prev_up, prev_down;
    logic             start_p, up_p, down_p;
    logic             up_step, down_step;
    logic             wrap, dec_zero, in_idle;

    assign in_idle = (st_q == ST_IDLE);

    btn_edge_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_up (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_up),
        .enable (in_idle),
        .inhibit(btn_down),
        .step   (up_step)
    );

    btn_edge_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_down (
        .clk    (clk),
        .rst    (rst),
        .btn    (btn_down),
        .enable (in_idle),
        .inhibit(btn_up),
        .step   (down_step)
    );

    always_comb begin
        start_p = btn_start & ~prev_start;
        up_p    = btn_up & ~prev_up;
        down_p  = btn_down & ~prev_down;
        wrap    = (presc_q == PS_LAST);
        mm_dec  = mm_q;
        ss_dec  = ss_q - 1'b1;
        if (ss_q == '0) begin
            ss_dec = SEC_MAX;
            mm_dec = mm_q - 1'b1;
        end
        dec_zero = (mm_dec == '0) && (ss_dec == '0);
    end

    always_comb begin
        st_n    = st_q;
        mm_n    = mm_q;
        ss_n    = ss_q;
        presc_n = presc_q;
        asec_n  = '0;
        unique case (st_q)
            ST_IDLE: begin
                ss_n    = '0;
                presc_n = '0;
                if (start_p) begin
                    if (mm_q != '0 || ss_q != '0)
                        st_n = ST_RUN;
                end else if (up_step && !down_step) begin
                    if (mm_q != MM_MAX)
                        mm_n = mm_q + 1'b1;
                end else if (down_step && !up_step) begin
                    if (mm_q != '0)
                        mm_n = mm_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (wrap) begin
                    presc_n = '0;
                    mm_n    = mm_dec;
                    ss_n    = ss_dec;
                    if (dec_zero)
                        st_n = ST_ALARM;
                    else if (start_p)
                        st_n = ST_PAUSE;
                end else if (start_p) begin
                    st_n = ST_PAUSE;
                end else begin
                    presc_n = presc_q + 1'b1;
                end
            end
            ST_PAUSE: begin
                if (down_p) begin
                    st_n = ST_IDLE;
                    mm_n = '0;
                    ss_n = '0;
                end else if (start_p) begin
                    st_n = ST_RUN;
                end
            end
            ST_ALARM: begin
                mm_n = '0;
                ss_n = '0;
                if (start_p || up_p || down_p) begin
                    st_n = ST_IDLE;
                end else if (wrap) begin
                    presc_n = '0;
                    if (asec_q == AS_LAST)
                        st_n = ST_IDLE;
                    else
                        asec_n = asec_q + 1'b1;
                end else begin
                    presc_n = presc_q + 1'b1;
                    asec_n  = asec_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            st_q       <= ST_IDLE;
            mm_q       <= '0;
            ss_q       <= '0;
            presc_q    <= '0;
            asec_q     <= '0;
            running_q  <= 1'b0;
            alarm_q    <= 1'b0;
            prev_start <= 1'b0;
            prev_up    <= 1'b0;
            prev_down  <= 1'b0;
        end else begin
            st_q       <= st_n;
            mm_q       <= mm_n;
            ss_q       <= ss_n;
            presc_q    <= presc_n;
            asec_q     <= asec_n;
            running_q  <= (st_n == ST_RUN);
            alarm_q    <= (st_n == ST_ALARM);
            prev_start <= btn_start;
            prev_up    <= btn_up;
            prev_down  <= btn_down;
        end
    end

    assign minutes = mm_q;
    assign seconds = ss_q;
    assign running = running_q;
    assign alarm   = alarm_q;
    assign state   = st_q;

endmodule
